// File: rtl/access_pkg.sv
// Shared types and helpers for the badge reader front end.
// Frame layout: P_E, data[31:0] MSB first, P_O.
package access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP,
        ST_CHECK,
        ST_FLUSH
    } state_e;

    localparam int FRAME_BITS  = 34;
    localparam int DATA_BITS   = 32;
    localparam int BIT_CNT_MAX = FRAME_BITS + 1;

    // Even parity bit covering the upper data half.
    function automatic logic even_ok(input logic p, input logic [15:0] d);
        return (p ^ (^d)) == 1'b0;
    endfunction

    // Odd parity bit covering the lower data half.
    function automatic logic odd_ok(input logic p, input logic [15:0] d);
        return (p ^ (^d)) == 1'b1;
    endfunction

endpackage

// File: rtl/badge_line_sync.sv
// Two-flop synchronizer for one Wiegand line.
// Resets to 1 so an idle (high) line never looks like a pulse.
module badge_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_n,
    output logic line_s
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous line through two flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= line_n;
            sync_q <= meta_q;
        end
    end

    assign line_s = sync_q;

endmodule

// File: rtl/badge_reader_rx.sv
// Wiegand 34-bit receiver: bit capture, length and parity check.
// id holds the last good frame; id_valid/frame_err are 1-cycle strobes.
module badge_reader_rx
    import access_pkg::*;
#(
    parameter int MIN_PULSE      = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d0_n,
    input  logic        d1_n,
    output logic [31:0] id,
    output logic        id_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MIN_P   = CW'(MIN_PULSE);
    localparam logic [5:0]    NBITS   = 6'(FRAME_BITS);
    localparam logic [5:0]    SATBITS = 6'(BIT_CNT_MAX);

    logic d0_s;
    logic d1_s;

    badge_line_sync u_sync_d0 (
        .clk    (clk),
        .reset  (reset),
        .line_n (d0_n),
        .line_s (d0_s)
    );

    badge_line_sync u_sync_d1 (
        .clk    (clk),
        .reset  (reset),
        .line_n (d1_n),
        .line_s (d1_s)
    );

    state_e      state_q, state_d;
    logic        line_q, line_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] gap_q, gap_d;
    logic [33:0] shift_q, shift_d;
    logic [5:0]  bits_q, bits_d;
    logic [31:0] id_q, id_d;
    logic        id_valid_q, id_valid_d;
    logic        frame_err_q, frame_err_d;

    logic line_lo;
    logic other_lo;
    logic frame_ok;

    // line_q=1 means the pulse being timed is on D1.
    assign line_lo  = line_q ? ~d1_s : ~d0_s;
    assign other_lo = line_q ? ~d0_s : ~d1_s;

    // shift_q[33]=P_E, shift_q[32:1]=data, shift_q[0]=P_O.
    assign frame_ok = (bits_q == NBITS)
                    && even_ok(shift_q[33], shift_q[32:17])
                    && odd_ok(shift_q[0], shift_q[16:1]);

    // Next-state and registered-output logic of the receiver.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        shift_d     = shift_q;
        bits_d      = bits_q;
        id_d        = id_q;
        id_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (d0_s ^ d1_s) begin
                    state_d = ST_PULSE;
                    line_d  = ~d1_s;
                    cnt_d   = '0;
                end
            end
            ST_PULSE: begin
                if (other_lo) begin
                    state_d     = ST_FLUSH;
                    frame_err_d = 1'b1;
                    gap_d       = '0;
                end else if (line_lo) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == TO_MAX) begin
                        state_d     = ST_FLUSH;
                        frame_err_d = 1'b1;
                        gap_d       = '0;
                    end
                end else if (cnt_q >= MIN_P) begin
                    shift_d = {shift_q[32:0], line_q};
                    if (bits_q != SATBITS) begin
                        bits_d = bits_q + 6'd1;
                    end
                    state_d = ST_GAP;
                    gap_d   = '0;
                end else begin
                    gap_d   = '0;
                    state_d = (bits_q != 6'd0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + CW'(1);
                if (!d0_s && !d1_s) begin
                    state_d     = ST_FLUSH;
                    frame_err_d = 1'b1;
                    gap_d       = '0;
                end else if (d0_s ^ d1_s) begin
                    state_d = ST_PULSE;
                    line_d  = ~d1_s;
                    cnt_d   = '0;
                end else if (gap_q == TO_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (frame_ok) begin
                    id_d       = shift_q[32:1];
                    id_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                bits_d  = '0;
                state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (!d0_s || !d1_s) begin
                    gap_d = '0;
                end else if (gap_q == TO_LAST) begin
                    gap_d   = '0;
                    bits_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All receiver state, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            line_q      <= 1'b0;
            cnt_q       <= '0;
            gap_q       <= '0;
            shift_q     <= '0;
            bits_q      <= '0;
            id_q        <= '0;
            id_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            shift_q     <= shift_d;
            bits_q      <= bits_d;
            id_q        <= id_d;
            id_valid_q  <= id_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign id        = id_q;
    assign id_valid  = id_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_badge_reader_rx.sv
// Scoreboarded bench for badge_reader_rx.
// Expected strobes are queued as frames are sent.
module tb_badge_reader_rx;

    localparam int MIN_PULSE = 4;
    localparam int TO        = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        d0_n;
    logic        d1_n;
    logic [31:0] id;
    logic        id_valid;
    logic        frame_err;
    logic        busy;

    always #5 clk = ~clk;

    badge_reader_rx #(
        .MIN_PULSE      (MIN_PULSE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d0_n      (d0_n),
        .d1_n      (d1_n),
        .id        (id),
        .id_valid  (id_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct packed {
        logic        is_valid;
        logic [31:0] id;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_id = 32'h0;

    // Every strobe is matched against the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (id_valid && frame_err) begin
            checks++;
            errors++;
            $display("FAIL strobe_overlap: id_valid=1 frame_err=1, required never both");
        end else if (id_valid || frame_err) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: id_valid=%0b frame_err=%0b id=%h, required no strobe",
                         id_valid, frame_err, id);
            end else begin
                e = exp_q.pop_front();
                if (id_valid !== e.is_valid || (e.is_valid && id !== e.id)) begin
                    errors++;
                    $display("FAIL strobe: got valid=%0b err=%0b id=%h, required valid=%0b id=%h",
                             id_valid, frame_err, id, e.is_valid, e.id);
                end
            end
        end
    end

    function automatic logic [63:0] make_frame(input logic [31:0] d, input logic pe, input logic po);
        return {30'b0, pe, d, po};
    endfunction

    function automatic logic [63:0] good_frame(input logic [31:0] d);
        return make_frame(d, ^d[31:16], ~(^d[15:0]));
    endfunction

    task automatic push_frame(input logic [63:0] v, input int n);
        logic ok;
        ok = (n == 34) && ((^v[33:17]) == 1'b0) && ((^v[16:0]) == 1'b1);
        if (ok) begin
            exp_q.push_back({1'b1, v[32:1]});
            last_id = v[32:1];
        end else begin
            exp_q.push_back({1'b0, 32'h0});
        end
    endtask

    task automatic send_bit(input logic b, input int low_cyc, input int gap);
        @(negedge clk);
        if (b) d1_n = 1'b0;
        else d0_n = 1'b0;
        repeat (low_cyc) @(negedge clk);
        d0_n = 1'b1;
        d1_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], 10, 50);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3 * TO + 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: pending=%0d busy=%b, required pending=0 busy=0",
                     name, exp_q.size(), busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (id !== last_id) begin
            errors++;
            $display("FAIL %s_id: id=%h, required %h", name, id, last_id);
        end
    endtask

    task automatic count_to_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (busy && n < 3 * TO);
        checks++;
        if (n != TO + 2) begin
            errors++;
            $display("FAIL %s_flush: busy fell after %0d cycles, required %0d", name, n, TO + 2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d0_n  = 1'b1;
        d1_n  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (id !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: id=%h busy=%b, required 0 0", id, busy);
        end
        checks++;
        if (id_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: id_valid=%b frame_err=%b, required 0 0", id_valid, frame_err);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [63:0] v;
        int n;
        v = make_frame(32'hDEADBEEF, 1'b1, 1'b0);
        push_frame(v, 34);
        for (int i = 33; i >= 1; i--) send_bit(v[i], 10, 50);
        @(negedge clk);
        d0_n = 1'b0;
        repeat (10) @(negedge clk);
        d0_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!id_valid && n < TO + 50);
        // Two extra cycles for the input synchronizer.
        checks++;
        if (n != TO + 4) begin
            errors++;
            $display("FAIL good_latency: id_valid after %0d cycles, required %0d", n, TO + 4);
        end
        wait_done("good");
    endtask

    task automatic test_parity_error();
        logic [63:0] v;
        v = make_frame(32'hDEADBEEF, 1'b1, 1'b1);
        push_frame(v, 34);
        send_bits(v, 34);
        wait_done("parity");
    endtask

    task automatic test_wrong_length();
        logic [63:0] v;
        v = 64'h0000_0000_02A5_5A5A;
        push_frame(v, 26);
        send_bits(v, 26);
        wait_done("len26");
        v = {make_frame(32'hDEADBEEF, 1'b1, 1'b0), 1'b1};
        push_frame(v, 35);
        send_bits(v, 35);
        wait_done("len35");
    endtask

    task automatic test_glitch();
        logic [63:0] v;
        v = make_frame(32'h0000_0001, 1'b0, 1'b0);
        push_frame(v, 34);
        for (int i = 33; i >= 0; i--) begin
            send_bit(v[i], 10, 50);
            if (i == 24) send_bit(1'b1, 2, 50);
        end
        wait_done("glitch");
    endtask

    task automatic test_collision();
        logic [63:0] v;
        v = good_frame(32'hCAFE_F00D);
        exp_q.push_back({1'b0, 32'h0});
        send_bits(v >> 24, 10);
        @(negedge clk);
        d0_n = 1'b0;
        d1_n = 1'b0;
        repeat (10) @(negedge clk);
        d0_n = 1'b1;
        d1_n = 1'b1;
        count_to_idle("collide");
        wait_done("collide");
        push_frame(v, 34);
        send_bits(v, 34);
        wait_done("collide_next");
    endtask

    task automatic test_stuck();
        logic [63:0] v;
        v = good_frame(32'h0BAD_C0DE);
        exp_q.push_back({1'b0, 32'h0});
        send_bits(v >> 24, 10);
        @(negedge clk);
        d0_n = 1'b0;
        repeat (2 * TO) @(negedge clk);
        d0_n = 1'b1;
        count_to_idle("stuck");
        wait_done("stuck");
        push_frame(v, 34);
        send_bits(v, 34);
        wait_done("stuck_next");
    endtask

    task automatic test_reset_mid();
        logic [63:0] v;
        v = good_frame(32'hFFFF_0000);
        send_bits(v >> 17, 17);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (id !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: id=%h busy=%b, required 0 0", id, busy);
        end
        @(negedge clk);
        reset   = 1'b0;
        last_id = 32'h0;
        repeat (TO + 20) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || id !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_quiet: pending=%0d id=%h, required 0 0", exp_q.size(), id);
        end
        v = make_frame(32'h1234_5678, 1'b1, 1'b1);
        push_frame(v, 34);
        send_bits(v, 34);
        wait_done("after_reset");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_wrong_length();
        test_glitch();
        test_collision();
        test_stuck();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
